// File: rtl/mem_spm_bus_if.sv
// MEM-stage memory-access front end: steers each load/store either to the
// scratchpad (zero wait states) or to the shared system bus via a
// request/grant/ready handshake, stalls the pipeline during bus accesses,
// and holds bus read data until the pipeline can take it.
// Optional feature macro: MEM_BUS_TIMEOUT_EN (bus-ready timeout with bus_err pulse).
module mem_spm_bus_if #(
    parameter int          ADDR_W     = 30,
    parameter int          DATA_W     = 32,
    parameter int          SPM_ADDR_W = 12,
    parameter logic [2:0]  SPM_SEL    = 3'b001
`ifdef MEM_BUS_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 255
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  as_,
    input  logic                  rw,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  busy,
    output logic [SPM_ADDR_W-1:0] spm_addr,
    output logic                  spm_as_,
    output logic                  spm_rw,
    output logic [DATA_W-1:0]     spm_wr_data,
    input  logic [DATA_W-1:0]     spm_rd_data,
    output logic                  bus_req_,
    input  logic                  bus_grnt_,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic                  bus_as_,
    output logic                  bus_rw,
    output logic [DATA_W-1:0]     bus_wr_data,
    input  logic [DATA_W-1:0]     bus_rd_data,
    input  logic                  bus_rdy_,
    output logic                  bus_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACCESS, ST_STALL} state_t;

    state_t              r_state, w_state_next;
    logic                r_bus_req, w_bus_req_next;
    logic                r_bus_as, w_bus_as_next;
    logic                r_bus_rw, w_bus_rw_next;
    logic [ADDR_W-1:0]   r_bus_addr, w_bus_addr_next;
    logic [DATA_W-1:0]   r_bus_wr_data, w_bus_wr_data_next;
    logic [DATA_W-1:0]   r_rd_buf, w_rd_buf_next;
    logic                w_spm_hit;
    logic                w_access;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic                r_bus_err, w_bus_err_next;
`endif

    assign w_spm_hit   = (addr[ADDR_W-1 -: 3] == SPM_SEL);
    assign w_access    = ~as_ & ~flush;

    // Scratchpad side is a pure pass-through except for the strobe.
    assign spm_addr    = addr[SPM_ADDR_W-1:0];
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;

    assign bus_req_    = r_bus_req;
    assign bus_as_     = r_bus_as;
    assign bus_rw      = r_bus_rw;
    assign bus_addr    = r_bus_addr;
    assign bus_wr_data = r_bus_wr_data;

`ifdef MEM_BUS_TIMEOUT_EN
    assign bus_err     = r_bus_err;
`else
    assign bus_err     = 1'b0;
`endif

    // Next-state, next-register values and combinational pipeline outputs.
    always_comb begin
        w_state_next       = r_state;
        w_bus_req_next     = r_bus_req;
        w_bus_as_next      = 1'b1;       // strobe is a single-cycle pulse
        w_bus_rw_next      = r_bus_rw;
        w_bus_addr_next    = r_bus_addr;
        w_bus_wr_data_next = r_bus_wr_data;
        w_rd_buf_next      = r_rd_buf;
        busy               = 1'b0;
        rd_data            = r_rd_buf;
        spm_as_            = 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
        w_cnt_next         = r_cnt;
        w_bus_err_next     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_spm_hit) begin
                        // RAM read latency is absorbed by the MEM/WB register.
                        spm_as_ = 1'b0;
                        rd_data = spm_rd_data;
                    end else begin
                        busy               = 1'b1;
                        w_bus_req_next     = 1'b0;
                        w_bus_addr_next    = addr;
                        w_bus_rw_next      = rw;
                        w_bus_wr_data_next = wr_data;
                        w_state_next       = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                busy = 1'b1;
                if (!bus_grnt_) begin
                    w_bus_as_next = 1'b0;
                    w_state_next  = ST_ACCESS;
`ifdef MEM_BUS_TIMEOUT_EN
                    w_cnt_next    = '0;
`endif
                end
            end
            ST_ACCESS: begin
                if (!bus_rdy_) begin
                    // Forward immediately and keep a copy in case the pipeline stalls.
                    rd_data        = bus_rd_data;
                    w_rd_buf_next  = bus_rd_data;
                    w_bus_req_next = 1'b1;
                    w_state_next   = stall ? ST_STALL : ST_IDLE;
`ifdef MEM_BUS_TIMEOUT_EN
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_rd_buf_next  = '0;
                    w_bus_req_next = 1'b1;
                    w_bus_err_next = 1'b1;
                    w_state_next   = stall ? ST_STALL : ST_IDLE;
                end else begin
                    busy       = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
`else
                end else begin
                    busy = 1'b1;
`endif
                end
            end
            ST_STALL: begin
                if (!stall) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and bus-side registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bus_req     <= 1'b1;
            r_bus_as      <= 1'b1;
            r_bus_rw      <= 1'b1;
            r_bus_addr    <= '0;
            r_bus_wr_data <= '0;
            r_rd_buf      <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
            r_cnt         <= '0;
            r_bus_err     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_bus_req     <= w_bus_req_next;
            r_bus_as      <= w_bus_as_next;
            r_bus_rw      <= w_bus_rw_next;
            r_bus_addr    <= w_bus_addr_next;
            r_bus_wr_data <= w_bus_wr_data_next;
            r_rd_buf      <= w_rd_buf_next;
`ifdef MEM_BUS_TIMEOUT_EN
            r_cnt         <= w_cnt_next;
            r_bus_err     <= w_bus_err_next;
`endif
        end
    end

endmodule

// File: tb/tb_mem_spm_bus_if.sv
// Self-checking bench for mem_spm_bus_if: directed test-plan steps followed by
// randomized scratchpad/bus/flush transactions checked against a
// transaction-level expectation model (latency, strobe timing, data hold).
module tb_mem_spm_bus_if;

    logic        clk = 1'b0;
    logic        reset, stall, flush, as_, rw, bus_grnt_, bus_rdy_;
    logic [29:0] addr;
    logic [31:0] wr_data, spm_rd_data, bus_rd_data;
    logic [31:0] rd_data, bus_wr_data, spm_wr_data;
    logic [29:0] bus_addr;
    logic [11:0] spm_addr;
    logic        busy, spm_as_, spm_rw, bus_req_, bus_as_, bus_rw, bus_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_buf;   // model of the held bus read data

    mem_spm_bus_if #(
`ifdef MEM_BUS_TIMEOUT_EN
        .TIMEOUT_CYC(8)
`endif
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data),
        .rd_data(rd_data), .busy(busy),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point lands 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] spm_address();
        logic [29:0] a;
        a = 30'($urandom);
        a[29:27] = 3'b001;
        return a;
    endfunction

    function automatic logic [29:0] bus_address();
        logic [29:0] a;
        int t;
        a = 30'($urandom);
        t = int'($urandom_range(0, 6));
        a[29:27] = (t >= 1) ? 3'(t + 1) : 3'b000;
        return a;
    endfunction

    task automatic idle_inputs();
        as_ = 1'b1; flush = 1'b0; stall = 1'b0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    endtask

    // Scratchpad access: strobe and pass-through in the same cycle, no busy.
    task automatic spm_txn(input logic [29:0] a, input logic rwv, input logic [31:0] wd,
                           input logic [31:0] sd);
        as_ = 1'b0; addr = a; rw = rwv; wr_data = wd; spm_rd_data = sd; flush = 1'b0;
        #1;
        chk("spm_as_", {31'b0, spm_as_}, 32'd0);
        chk("spm_busy", {31'b0, busy}, 32'd0);
        chk("spm_addr", {20'b0, spm_addr}, {20'b0, a[11:0]});
        chk("spm_rw", {31'b0, spm_rw}, {31'b0, rwv});
        chk("spm_wr_data", spm_wr_data, wd);
        chk("spm_rd_data", rd_data, sd);
        step();
        chk("spm_no_bus_req", {31'b0, bus_req_}, 32'd1);
        idle_inputs();
        $display("SPM  addr=%h rw=%0d wd=%h rd=%h", a, rwv, wd, sd);
    endtask

    // Bus access: g cycles to grant, r cycles in ACCESS before ready, sh stall-hold cycles.
    task automatic bus_txn(input logic [29:0] a, input logic rwv, input logic [31:0] wd,
                           input int g, input int r, input logic [31:0] rdv, input int sh,
                           input logic noisy);
        // IDLE: request decided; grant/ready in this cycle must be ignored.
        as_ = 1'b0; addr = a; rw = rwv; wr_data = wd; flush = 1'b0; stall = 1'b0;
        bus_grnt_ = noisy ? 1'($urandom) : 1'b1;
        bus_rdy_  = noisy ? 1'($urandom) : 1'b1;
        #1;
        chk("bus_busy_idle", {31'b0, busy}, 32'd1);
        chk("bus_no_spm", {31'b0, spm_as_}, 32'd1);
        step();
        chk("bus_req_low", {31'b0, bus_req_}, 32'd0);
        chk("bus_addr", {2'b0, bus_addr}, {2'b0, a});
        chk("bus_rw", {31'b0, bus_rw}, {31'b0, rwv});
        chk("bus_wr_data", bus_wr_data, wd);
        // REQ: inputs change freely; strobe must not reach the scratchpad.
        for (int i = 0; i <= g; i++) begin
            as_ = noisy ? 1'($urandom) : 1'b1; addr = spm_address(); rw = 1'($urandom);
            wr_data = $urandom; flush = noisy ? 1'($urandom) : 1'b0;
            bus_grnt_ = (i == g) ? 1'b0 : 1'b1;
            bus_rdy_ = noisy ? 1'($urandom) : 1'b1;
            #1;
            chk("req_busy", {31'b0, busy}, 32'd1);
            chk("req_spm_as_", {31'b0, spm_as_}, 32'd1);
            chk("req_bus_as_", {31'b0, bus_as_}, 32'd1);
            chk("req_rd_data", rd_data, exp_buf);
            step();
        end
        // ACCESS: strobe low only in the first cycle.
        for (int j = 0; j < r; j++) begin
            bus_grnt_ = noisy ? 1'($urandom) : 1'b1; bus_rdy_ = 1'b1;
            flush = noisy ? 1'($urandom) : 1'b0;
            #1;
            chk("acc_bus_as_", {31'b0, bus_as_}, (j == 0) ? 32'd0 : 32'd1);
            chk("acc_busy", {31'b0, busy}, 32'd1);
            chk("acc_req_held", {31'b0, bus_req_}, 32'd0);
            step();
        end
        bus_rdy_ = 1'b0; bus_rd_data = rdv; stall = (sh > 0);
        #1;
        chk("rdy_bus_as_", {31'b0, bus_as_}, (r == 0) ? 32'd0 : 32'd1);
        chk("rdy_busy", {31'b0, busy}, 32'd0);
        chk("rdy_rd_data", rd_data, rdv);
        step();
        exp_buf = rdv;
        chk("post_req_released", {31'b0, bus_req_}, 32'd1);
        // STALL: data held, bus handshake inputs ignored.
        as_ = 1'b1;
        for (int k = 0; k < sh; k++) begin
            stall = (k < sh - 1);
            bus_grnt_ = 1'($urandom); bus_rdy_ = 1'($urandom); bus_rd_data = $urandom;
            #1;
            chk("stall_busy", {31'b0, busy}, 32'd0);
            chk("stall_rd_data", rd_data, exp_buf);
            step();
            chk("stall_req", {31'b0, bus_req_}, 32'd1);
        end
        idle_inputs();
        #1;
        chk("back_idle_rd_data", rd_data, exp_buf);
        chk("back_idle_busy", {31'b0, busy}, 32'd0);
        chk("back_idle_bus_as_", {31'b0, bus_as_}, 32'd1);
        chk("bus_err_quiet", {31'b0, bus_err}, 32'd0);
        $display("BUS  addr=%h rw=%0d wd=%h g=%0d r=%0d rd=%h stall=%0d", a, rwv, wd, g, r, rdv, sh);
    endtask

    initial begin
        reset = 1'b1; idle_inputs(); addr = '0; rw = 1'b1; wr_data = '0;
        spm_rd_data = '0; bus_rd_data = '0; exp_buf = '0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_bus_req_", {31'b0, bus_req_}, 32'd1);
        chk("rst_bus_as_", {31'b0, bus_as_}, 32'd1);
        chk("rst_bus_rw", {31'b0, bus_rw}, 32'd1);
        chk("rst_bus_addr", {2'b0, bus_addr}, 32'd0);
        chk("rst_bus_wr_data", bus_wr_data, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        step();

        // Directed test-plan steps.
        spm_txn(30'h0800_0010, 1'b1, 32'h0, 32'hCAFE_F00D);
        spm_txn(30'h0800_0010, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_0BAD);
        bus_txn(30'h1000_0004, 1'b1, 32'h0, 2, 3, 32'h1234_5678, 0, 1'b0);
        bus_txn(30'h1000_0004, 1'b1, 32'h0, 2, 3, 32'h1234_5678, 4, 1'b0);

        // Flush in IDLE: no strobe on either target.
        as_ = 1'b0; flush = 1'b1; addr = spm_address();
        #1;
        chk("flush_spm_as_", {31'b0, spm_as_}, 32'd1);
        chk("flush_busy", {31'b0, busy}, 32'd0);
        step();
        addr = bus_address();
        #1;
        chk("flush_bus_busy", {31'b0, busy}, 32'd0);
        step();
        chk("flush_bus_req_", {31'b0, bus_req_}, 32'd1);
        chk("flush_bus_as_", {31'b0, bus_as_}, 32'd1);
        idle_inputs();
        $display("FLUSH idle access suppressed");

        // Reset while in ACCESS.
        as_ = 1'b0; addr = bus_address(); rw = 1'b0; wr_data = 32'hA5A5_5A5A;
        step();
        as_ = 1'b1; bus_grnt_ = 1'b0;
        step();
        bus_grnt_ = 1'b1;
        #1;
        chk("acc_before_reset_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hFFFF_0000;
        step();
        reset = 1'b0; bus_rdy_ = 1'b1;
        #1;
        exp_buf = '0;
        chk("rstacc_bus_req_", {31'b0, bus_req_}, 32'd1);
        chk("rstacc_bus_as_", {31'b0, bus_as_}, 32'd1);
        chk("rstacc_rd_data", rd_data, 32'd0);
        chk("rstacc_busy", {31'b0, busy}, 32'd0);
        chk("rstacc_bus_addr", {2'b0, bus_addr}, 32'd0);
        step();
        $display("RESET during ACCESS");

`ifdef MEM_BUS_TIMEOUT_EN
        // Timeout: ready never arrives.
        as_ = 1'b0; addr = bus_address(); rw = 1'b1;
        step();
        as_ = 1'b1; bus_grnt_ = 1'b0;
        step();
        bus_grnt_ = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("to_busy", {31'b0, busy}, (c == 7) ? 32'd0 : 32'd1);
            chk("to_err_low", {31'b0, bus_err}, 32'd0);
            step();
        end
        chk("to_err_pulse", {31'b0, bus_err}, 32'd1);
        chk("to_rd_data", rd_data, 32'd0);
        chk("to_busy_after", {31'b0, busy}, 32'd0);
        chk("to_req_", {31'b0, bus_req_}, 32'd1);
        step();
        chk("to_err_once", {31'b0, bus_err}, 32'd0);
        $display("TIMEOUT after 8 ACCESS cycles");
`endif

        // Randomized mix of transactions.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: spm_txn(spm_address(), 1'($urandom), $urandom, $urandom);
                1, 2: bus_txn(bus_address(), 1'($urandom), $urandom,
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                              $urandom, int'($urandom_range(0, 3)), 1'b1);
                default: begin
                    as_ = 1'b0; flush = 1'b1; addr = 30'($urandom);
                    #1;
                    chk("rflush_spm_as_", {31'b0, spm_as_}, 32'd1);
                    chk("rflush_busy", {31'b0, busy}, 32'd0);
                    step();
                    chk("rflush_bus_req_", {31'b0, bus_req_}, 32'd1);
                    idle_inputs();
                    $display("FLUSH addr=%h", addr);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
